reg_access_arbiter: RTL and testbench

Shared register bank that sits between the I2C slave's register interface (the host port) and on-chip fabric logic (the local port).
- Host reads are combinational and never stall, so the slave can load read data on the same cycle as its read strobe.
- Host writes always win the single write port; local accesses use a req/gnt handshake.
- Per-register dirty flags and an interrupt tell fabric logic which registers the I2C master has written.

---
 rtl/reg_access_arbiter.sv | 130 +++++++++++++
 tb/tb_reg_access_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// Shared 8-bit register bank between the I2C slave host port and a fabric-side
// local port. Host writes always own the write port; local accesses use req/gnt.
module reg_access_arbiter #(
   parameter int         NUM_REGS       = 16,
   parameter logic [7:0] ID_VALUE       = 8'hA5,
   parameter logic [7:0] UNMAPPED_RDATA = 8'hFF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          host_addr,
   input  logic [7:0]          host_wdata,
   input  logic                host_wr,
   input  logic                host_rd,
   output logic [7:0]          host_rdata,
   input  logic                local_req,
   input  logic                local_we,
   input  logic [7:0]          local_addr,
   input  logic [7:0]          local_wdata,
   output logic                local_gnt,
   output logic [7:0]          local_rdata,
   output logic [NUM_REGS-1:0] dirty,
   input  logic [NUM_REGS-1:0] dirty_clr,
   output logic                irq,
   output logic [15:0]         host_rd_count
);

   localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

   typedef enum logic {
      L_IDLE,
      L_GNT
   } lstate_t;

   lstate_t    lstate;
   logic [7:0] regs [NUM_REGS];
   logic [7:0] local_rd_value;
   logic       host_we;
   logic       local_accept;
   logic       local_wr_en;
   logic [NUM_REGS-1:0] dirty_set;

   // Register 0 is the read-only ID; the full 8-bit address is compared so
   // nothing aliases onto the implemented range.
   function automatic logic writable(input logic [7:0] a);
      return (a != 8'd0) && ({1'b0, a} < NUM_REGS_W);
   endfunction

   // Host read path is purely combinational so the slave can latch data on its strobe.
   always_comb begin
      host_rdata = UNMAPPED_RDATA;
      if (host_addr == 8'd0)
         host_rdata = ID_VALUE;
      else if ({1'b0, host_addr} < NUM_REGS_W)
         host_rdata = regs[host_addr[AW-1:0]];
   end

   always_comb begin
      local_rd_value = UNMAPPED_RDATA;
      if (local_addr == 8'd0)
         local_rd_value = ID_VALUE;
      else if ({1'b0, local_addr} < NUM_REGS_W)
         local_rd_value = regs[local_addr[AW-1:0]];
   end

   // A local access is only taken on a cycle with no host write, so the two
   // writers never share an edge and a colliding local write lands last.
   assign host_we      = host_wr && writable(host_addr);
   assign local_accept = (lstate == L_IDLE) && local_req && !host_wr;
   assign local_wr_en  = local_accept && local_we && writable(local_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= 8'h00;
      end else if (host_we) begin
         regs[host_addr[AW-1:0]] <= host_wdata;
      end else if (local_wr_en) begin
         regs[local_addr[AW-1:0]] <= local_wdata;
      end
   end

   // Local handshake: the access happens on the accepting edge, the grant
   // cycle follows, and the FSM always returns to idle afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         lstate      <= L_IDLE;
         local_rdata <= 8'h00;
      end else begin
         case (lstate)
            L_IDLE: begin
               if (local_accept) begin
                  lstate <= L_GNT;
                  if (!local_we)
                     local_rdata <= local_rd_value;
               end
            end
            L_GNT:   lstate <= L_IDLE;
            default: lstate <= L_IDLE;
         endcase
      end
   end

   assign local_gnt = (lstate == L_GNT);

   always_comb begin
      dirty_set = '0;
      if (host_we)
         dirty_set[host_addr[AW-1:0]] = 1'b1;
   end

   // A host write setting a flag beats a clear of that flag in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         dirty <= '0;
         irq   <= 1'b0;
      end else begin
         dirty <= (dirty & ~dirty_clr) | dirty_set;
         irq   <= |dirty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         host_rd_count <= 16'h0000;
      else if (host_rd && (host_rd_count != 16'hFFFF))
         host_rd_count <= host_rd_count + 16'd1;
   end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Self-checking bench for reg_access_arbiter: directed scenarios plus random
// traffic compared against a behavioural register-bank model.
module tb_reg_access_arbiter;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   host_addr, host_wdata, host_rdata;
   logic         host_wr, host_rd;
   logic         local_req, local_we, local_gnt;
   logic [7:0]   local_addr, local_wdata, local_rdata;
   logic [N-1:0] dirty, dirty_clr;
   logic         irq;
   logic [15:0]  host_rd_count;

   int checks = 0;
   int errors = 0;

   logic [7:0]   m_mem [256];
   logic [N-1:0] m_dirty;
   logic         m_irq, m_gnt;
   logic [7:0]   m_rdata;
   int           m_count;

   always #5 clk = ~clk;

   reg_access_arbiter #(.NUM_REGS(N), .ID_VALUE(8'hA5), .UNMAPPED_RDATA(8'hFF)) dut (
      .clk(clk), .rst(rst),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_wr(host_wr), .host_rd(host_rd),
      .host_rdata(host_rdata),
      .local_req(local_req), .local_we(local_we), .local_addr(local_addr),
      .local_wdata(local_wdata), .local_gnt(local_gnt), .local_rdata(local_rdata),
      .dirty(dirty), .dirty_clr(dirty_clr), .irq(irq), .host_rd_count(host_rd_count)
   );

   function automatic logic [7:0] m_read(input logic [7:0] a);
      if (a == 8'd0) return 8'hA5;
      if (a < N) return m_mem[a];
      return 8'hFF;
   endfunction

   // Model of one clock edge, computed from the inputs applied before it.
   task automatic model_update();
      logic accept;
      if (rst) begin
         for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
         m_dirty = '0; m_irq = 1'b0; m_gnt = 1'b0; m_rdata = 8'h00; m_count = 0;
      end else begin
         accept  = local_req && !host_wr && !m_gnt;
         m_irq   = |m_dirty;
         m_dirty = m_dirty & ~dirty_clr;
         if (host_wr && host_addr != 8'd0 && host_addr < N) begin
            m_mem[host_addr] = host_wdata;
            m_dirty[host_addr[3:0]] = 1'b1;
         end
         if (accept) begin
            if (local_we) begin
               if (local_addr != 8'd0 && local_addr < N) m_mem[local_addr] = local_wdata;
            end else begin
               m_rdata = m_read(local_addr);
            end
         end
         m_gnt = accept;
         if (host_rd && m_count < 65535) m_count++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic applyStimulus();
      host_addr = 8'h00; host_wdata = 8'h00; host_wr = 1'b0; host_rd = 1'b0;
      local_req = 1'b0; local_we = 1'b0; local_addr = 8'h00; local_wdata = 8'h00;
      dirty_clr = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus();
      tick(); tick();
      rst = 1'b0;
      checks++; if (local_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt got %b exp 0", local_gnt); end
      checks++; if (local_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata got %h exp 00", local_rdata); end
      checks++; if (dirty !== '0) begin errors++; $display("[TB] FAIL reset_dirty got %h exp 0", dirty); end
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %b exp 0", irq); end
      checks++; if (host_rd_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_count got %h exp 0", host_rd_count); end
      host_addr = 8'h00; #1;
      checks++; if (host_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL read_id got %h exp a5", host_rdata); end
      host_addr = 8'h03; #1;
      checks++; if (host_rdata !== 8'h00) begin errors++; $display("[TB] FAIL read_reg3 got %h exp 00", host_rdata); end
      host_addr = 8'h40; #1;
      checks++; if (host_rdata !== 8'hFF) begin errors++; $display("[TB] FAIL read_unmapped got %h exp ff", host_rdata); end
      host_addr = 8'h10; #1;
      checks++; if (host_rdata !== 8'hFF) begin errors++; $display("[TB] FAIL read_addr16 got %h exp ff", host_rdata); end
   endtask

   task automatic test_host_write_dirty();
      host_addr = 8'h03; host_wdata = 8'h5C; host_wr = 1'b1; #1;
      checks++; if (host_rdata !== 8'h00) begin errors++; $display("[TB] FAIL same_cycle_write got %h exp 00", host_rdata); end
      tick();
      host_wr = 1'b0; #1;
      checks++; if (host_rdata !== 8'h5C) begin errors++; $display("[TB] FAIL host_write got %h exp 5c", host_rdata); end
      checks++; if (dirty !== 16'h0008) begin errors++; $display("[TB] FAIL dirty_set got %h exp 0008", dirty); end
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_lag got %b exp 0", irq); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_set got %b exp 1", irq); end
      dirty_clr = 16'h0008;
      tick();
      dirty_clr = '0;
      checks++; if (dirty !== 16'h0000) begin errors++; $display("[TB] FAIL dirty_clr got %h exp 0", dirty); end
      tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clr got %b exp 0", irq); end
   endtask

   task automatic test_local_access();
      local_req = 1'b1; local_we = 1'b0; local_addr = 8'h03;
      checks++; if (local_gnt !== 1'b0) begin errors++; $display("[TB] FAIL gnt_before got %b exp 0", local_gnt); end
      tick();
      local_req = 1'b0;
      checks++; if (local_gnt !== 1'b1) begin errors++; $display("[TB] FAIL local_rd_gnt got %b exp 1", local_gnt); end
      checks++; if (local_rdata !== 8'h5C) begin errors++; $display("[TB] FAIL local_rdata got %h exp 5c", local_rdata); end
      tick();
      checks++; if (local_gnt !== 1'b0) begin errors++; $display("[TB] FAIL gnt_pulse got %b exp 0", local_gnt); end
      local_req = 1'b1; local_we = 1'b1; local_addr = 8'h05; local_wdata = 8'h11;
      tick();
      local_req = 1'b0;
      checks++; if (local_gnt !== 1'b1) begin errors++; $display("[TB] FAIL local_wr_gnt got %b exp 1", local_gnt); end
      checks++; if (local_rdata !== 8'h5C) begin errors++; $display("[TB] FAIL rdata_hold got %h exp 5c", local_rdata); end
      host_addr = 8'h05; #1;
      checks++; if (host_rdata !== 8'h11) begin errors++; $display("[TB] FAIL local_write got %h exp 11", host_rdata); end
      checks++; if (dirty[5] !== 1'b0) begin errors++; $display("[TB] FAIL local_no_dirty got %b exp 0", dirty[5]); end
      tick();
   endtask

   task automatic test_collision();
      host_addr = 8'h07; host_wdata = 8'h99; host_wr = 1'b1;
      local_req = 1'b1; local_we = 1'b1; local_addr = 8'h07; local_wdata = 8'h22;
      tick();
      host_wr = 1'b0; #1;
      checks++; if (local_gnt !== 1'b0) begin errors++; $display("[TB] FAIL collide_nognt got %b exp 0", local_gnt); end
      checks++; if (host_rdata !== 8'h99) begin errors++; $display("[TB] FAIL collide_host got %h exp 99", host_rdata); end
      tick();
      local_req = 1'b0; #1;
      checks++; if (local_gnt !== 1'b1) begin errors++; $display("[TB] FAIL collide_gnt got %b exp 1", local_gnt); end
      checks++; if (host_rdata !== 8'h22) begin errors++; $display("[TB] FAIL collide_final got %h exp 22", host_rdata); end
      checks++; if (dirty[7] !== 1'b1) begin errors++; $display("[TB] FAIL collide_dirty got %b exp 1", dirty[7]); end
      tick();
   endtask

   task automatic test_ignored_writes();
      dirty_clr = '1;
      tick();
      dirty_clr = '0;
      host_addr = 8'h00; host_wdata = 8'h3C; host_wr = 1'b1;
      tick();
      host_addr = 8'h20; host_wdata = 8'h77;
      tick();
      host_wr = 1'b0; host_addr = 8'h00; #1;
      checks++; if (host_rdata !== 8'hA5) begin errors++; $display("[TB] FAIL id_readonly got %h exp a5", host_rdata); end
      checks++; if (dirty !== 16'h0000) begin errors++; $display("[TB] FAIL ignored_dirty got %h exp 0", dirty); end
      host_addr = 8'h02; host_wdata = 8'h44; host_wr = 1'b1; dirty_clr = 16'h0004;
      tick();
      host_wr = 1'b0; dirty_clr = '0;
      checks++; if (dirty !== 16'h0004) begin errors++; $display("[TB] FAIL set_beats_clr got %h exp 0004", dirty); end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         host_wr    = ($urandom_range(0, 9) < 3);
         host_rd    = ($urandom_range(0, 3) == 0);
         host_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
         host_wdata = 8'($urandom);
         dirty_clr  = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
         if (!local_req && $urandom_range(0, 2) == 0) begin
            local_req   = 1'b1;
            local_we    = $urandom_range(0, 1) == 1;
            local_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
            local_wdata = 8'($urandom);
         end
         #1;
         checks++; if (host_rdata !== m_read(host_addr)) begin errors++; $display("[TB] FAIL rnd_host_rdata addr %h got %h exp %h", host_addr, host_rdata, m_read(host_addr)); end
         tick();
         if (m_gnt) local_req = 1'b0;
         checks++; if (local_gnt !== m_gnt) begin errors++; $display("[TB] FAIL rnd_gnt got %b exp %b", local_gnt, m_gnt); end
         checks++; if (local_rdata !== m_rdata) begin errors++; $display("[TB] FAIL rnd_local_rdata got %h exp %h", local_rdata, m_rdata); end
         checks++; if (dirty !== m_dirty) begin errors++; $display("[TB] FAIL rnd_dirty got %h exp %h", dirty, m_dirty); end
         checks++; if (irq !== m_irq) begin errors++; $display("[TB] FAIL rnd_irq got %b exp %b", irq, m_irq); end
         checks++; if (host_rd_count !== 16'(m_count)) begin errors++; $display("[TB] FAIL rnd_count got %0d exp %0d", host_rd_count, m_count); end
      end
      applyStimulus();
      tick(); tick();
   endtask

   task automatic test_reset_mid_grant();
      host_addr = 8'h03; host_wdata = 8'h6B; host_wr = 1'b1;
      tick();
      host_wr = 1'b0;
      local_req = 1'b1; local_we = 1'b0; local_addr = 8'h03;
      tick();
      local_req = 1'b0;
      checks++; if (local_gnt !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_gnt got %b exp 1", local_gnt); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (local_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_gnt got %b exp 0", local_gnt); end
      checks++; if (local_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_mid_rdata got %h exp 00", local_rdata); end
      checks++; if (dirty !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mid_dirty got %h exp 0", dirty); end
      for (int a = 1; a < N; a++) begin
         host_addr = 8'(a); #1;
         checks++; if (host_rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_clear addr %0d got %h exp 00", a, host_rdata); end
      end
      tick();
      checks++; if (local_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_dropped got %b exp 0", local_gnt); end
   endtask

   task automatic test_rd_count_saturation();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      host_rd = 1'b1;
      repeat (100) tick();
      checks++; if (host_rd_count !== 16'd100) begin errors++; $display("[TB] FAIL count_100 got %0d exp 100", host_rd_count); end
      repeat (65434) tick();
      checks++; if (host_rd_count !== 16'hFFFE) begin errors++; $display("[TB] FAIL count_fffe got %h exp fffe", host_rd_count); end
      repeat (6) tick();
      host_rd = 1'b0;
      checks++; if (host_rd_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL count_sat got %h exp ffff", host_rd_count); end
      checks++; if (host_rd_count !== 16'(m_count)) begin errors++; $display("[TB] FAIL count_model got %0d exp %0d", host_rd_count, m_count); end
   endtask

   initial begin
      test_reset();
      test_host_write_dirty();
      test_local_access();
      test_collision();
      test_ignored_writes();
      test_random();
      test_reset_mid_grant();
      test_rd_count_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
